// File: rtl/clkdiv_frame_align_if.sv
// clkdiv_frame_align_if: frame-word input and alignment status bundle.
// master drives the frame words, slave is the alignment controller.
interface clkdiv_frame_align_if;
  logic       align_start;
  logic [7:0] frame_data;
  logic       bit_slip;
  logic       aligned;
  logic       align_fail;
  logic       lock_lost;
  logic [3:0] slip_count;

  modport master (
    output align_start,
    output frame_data,
    input  bit_slip,
    input  aligned,
    input  align_fail,
    input  lock_lost,
    input  slip_count
  );

  modport slave (
    input  align_start,
    input  frame_data,
    output bit_slip,
    output aligned,
    output align_fail,
    output lock_lost,
    output slip_count
  );
endinterface

// File: rtl/clkdiv_frame_align.sv
// clkdiv_frame_align: slips the word boundary until frame words lock.
// Option: CLKDIV_FRAME_ALIGN_AUTO_REALIGN_EN re-slips on lock loss.
module clkdiv_frame_align #(
  parameter logic [7:0] FRAME_PATTERN = 8'hF0,
  parameter int MATCH_COUNT   = 16,
  parameter int SETTLE_CYCLES = 8,
  parameter int MAX_SLIPS     = 8
) (
  input logic clk,
  input logic rst,
  clkdiv_frame_align_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    SLIP,
    SETTLE,
    LOCKED,
    FAIL
  } state_t;

  localparam logic [7:0] MATCH_LAST = 8'(MATCH_COUNT - 1);
  localparam logic [7:0] SETTLE_LD  = 8'(SETTLE_CYCLES);
  localparam logic [3:0] SLIP_MAX   = 4'(MAX_SLIPS);

  state_t     state, state_nxt;
  logic [7:0] match_cnt, match_nxt;
  logic [7:0] settle_cnt, settle_nxt;
  logic [3:0] slip_cnt, slip_nxt;
  logic       lost, lost_nxt;
  logic       slip_q, aligned_q, fail_q;
  logic       hit;

  assign hit = (bus.frame_data == FRAME_PATTERN);

  // Next state and next counter values; a start request overrides all.
  always_comb begin
    state_nxt  = state;
    match_nxt  = match_cnt;
    settle_nxt = settle_cnt;
    slip_nxt   = slip_cnt;
    lost_nxt   = lost;
    if (bus.align_start) begin
      state_nxt  = CHECK;
      match_nxt  = '0;
      settle_nxt = '0;
      slip_nxt   = '0;
      lost_nxt   = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state_nxt = IDLE;
        end
        CHECK: begin
          if (hit) begin
            if (match_cnt == MATCH_LAST) begin
              state_nxt = LOCKED;
              match_nxt = '0;
            end else begin
              match_nxt = match_cnt + 8'd1;
            end
          end else begin
            match_nxt = '0;
            if (slip_cnt == SLIP_MAX)
              state_nxt = FAIL;
            else
              state_nxt = SLIP;
          end
        end
        SLIP: begin
          slip_nxt   = (slip_cnt == 4'hF) ? slip_cnt
                                          : slip_cnt + 4'd1;
          settle_nxt = SETTLE_LD;
          state_nxt  = SETTLE;
        end
        SETTLE: begin
          if (settle_cnt <= 8'd1) begin
            settle_nxt = '0;
            state_nxt  = CHECK;
          end else begin
            settle_nxt = settle_cnt - 8'd1;
          end
        end
        LOCKED: begin
          if (!hit) begin
            lost_nxt  = 1'b1;
            match_nxt = '0;
`ifdef CLKDIV_FRAME_ALIGN_AUTO_REALIGN_EN
            slip_nxt  = '0;
            state_nxt = SLIP;
`else
            state_nxt = IDLE;
`endif
          end
        end
        FAIL: begin
          state_nxt = FAIL;
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  // State and counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      match_cnt  <= '0;
      settle_cnt <= '0;
      slip_cnt   <= '0;
      lost       <= 1'b0;
    end else begin
      state      <= state_nxt;
      match_cnt  <= match_nxt;
      settle_cnt <= settle_nxt;
      slip_cnt   <= slip_nxt;
      lost       <= lost_nxt;
    end
  end

  // Registered status flags decoded from the upcoming state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slip_q    <= 1'b0;
      aligned_q <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      slip_q    <= (state_nxt == SLIP);
      aligned_q <= (state_nxt == LOCKED);
      fail_q    <= (state_nxt == FAIL);
    end
  end

  assign bus.bit_slip   = slip_q;
  assign bus.aligned    = aligned_q;
  assign bus.align_fail = fail_q;
  assign bus.lock_lost  = lost;
  assign bus.slip_count = slip_cnt;

endmodule

// File: tb/tb_clkdiv_frame_align.sv
// tb_clkdiv_frame_align: vector table, directed corners, random vs model.
// Model is cycle-stamp based, independent of the controller's encoding.
module tb_clkdiv_frame_align;

  localparam logic [7:0] PAT = 8'hF0;
  localparam int MC = 16;
  localparam int SC = 8;
  localparam int MS = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  clkdiv_frame_align_if bus();

  clkdiv_frame_align #(
    .FRAME_PATTERN(PAT),
    .MATCH_COUNT(MC),
    .SETTLE_CYCLES(SC),
    .MAX_SLIPS(MS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [7:0] outs();
    return {bus.bit_slip, bus.aligned, bus.align_fail,
            bus.lock_lost, bus.slip_count};
  endfunction

  function automatic logic [7:0] ex(input logic s, input logic a,
                                    input logic f, input logic l,
                                    input int c);
    return {s, a, f, l, 4'(c)};
  endfunction

  function automatic logic [7:0] rot(input logic [7:0] v, input int k);
    logic [7:0] r;
    r = v;
    for (int i = 0; i < k; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.align_start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Behavioural model: attempt progress tracked with cycle stamps.
  bit m_active, m_locked, m_failed, m_lost, m_pend;
  int m_run, m_slips, m_resume, m_cyc;

  task automatic model_reset();
    m_active = 0; m_locked = 0; m_failed = 0;
    m_lost = 0; m_pend = 0;
    m_run = 0; m_slips = 0; m_resume = 0; m_cyc = 0;
  endtask

  task automatic model_step(input logic st, input logic [7:0] d);
    m_cyc++;
    if (st) begin
      m_active = 1; m_locked = 0; m_failed = 0; m_lost = 0;
      m_run = 0; m_slips = 0; m_pend = 0;
      m_resume = m_cyc + 1;
    end else if (m_pend) begin
      m_pend = 0;
      m_slips = (m_slips < 15) ? m_slips + 1 : 15;
      m_resume = m_cyc + SC + 1;
    end else if (m_active && m_cyc >= m_resume) begin
      if (m_locked) begin
        if (d != PAT) begin
          m_lost = 1;
          m_locked = 0;
`ifdef CLKDIV_FRAME_ALIGN_AUTO_REALIGN_EN
          m_slips = 0;
          m_pend = 1;
`else
          m_active = 0;
`endif
        end
      end else if (d == PAT) begin
        m_run++;
        if (m_run == MC) begin
          m_locked = 1;
          m_run = 0;
        end
      end else begin
        m_run = 0;
        if (m_slips == MS) begin
          m_failed = 1;
          m_active = 0;
        end else begin
          m_pend = 1;
        end
      end
    end
  endtask

  function automatic logic [7:0] model_out();
    return {m_pend, m_locked, m_failed, m_lost, 4'(m_slips)};
  endfunction

  typedef struct {
    logic       st;
    logic [7:0] d;
    int         n;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[16];

  int off, pulses, last, cyc;
  bit bad;
  logic st;
  logic [7:0] d;

  initial begin
    tbl[0]  = '{1'b1, 8'hF0, 1,  ex(0, 0, 0, 0, 0)};
    tbl[1]  = '{1'b0, 8'hF0, 15, ex(0, 0, 0, 0, 0)};
    tbl[2]  = '{1'b0, 8'hF0, 1,  ex(0, 1, 0, 0, 0)};
`ifdef CLKDIV_FRAME_ALIGN_AUTO_REALIGN_EN
    tbl[3]  = '{1'b0, 8'hE1, 1,  ex(1, 0, 0, 1, 0)};
    tbl[4]  = '{1'b0, 8'hF0, 20, ex(0, 0, 0, 1, 1)};
`else
    tbl[3]  = '{1'b0, 8'hE1, 1,  ex(0, 0, 0, 1, 0)};
    tbl[4]  = '{1'b0, 8'hF0, 20, ex(0, 0, 0, 1, 0)};
`endif
    tbl[5]  = '{1'b1, 8'hF0, 1,  ex(0, 0, 0, 0, 0)};
    tbl[6]  = '{1'b0, 8'h00, 1,  ex(1, 0, 0, 0, 0)};
    tbl[7]  = '{1'b0, 8'h00, 1,  ex(0, 0, 0, 0, 1)};
    tbl[8]  = '{1'b0, 8'h00, 8,  ex(0, 0, 0, 0, 1)};
    tbl[9]  = '{1'b0, 8'h00, 1,  ex(1, 0, 0, 0, 1)};
    tbl[10] = '{1'b0, 8'h00, 60, ex(1, 0, 0, 0, 7)};
    tbl[11] = '{1'b0, 8'h00, 1,  ex(0, 0, 0, 0, 8)};
    tbl[12] = '{1'b0, 8'h00, 9,  ex(0, 0, 1, 0, 8)};
    tbl[13] = '{1'b0, 8'h00, 30, ex(0, 0, 1, 0, 8)};
    tbl[14] = '{1'b1, 8'hF0, 1,  ex(0, 0, 0, 0, 0)};
    tbl[15] = '{1'b0, 8'hF0, 16, ex(0, 1, 0, 0, 0)};

    bus.align_start = 1'b0;
    bus.frame_data  = 8'h00;
    #2;
    chk("reset_state", outs(), 8'h00);
    @(negedge clk);
    rst = 1'b0;

    // Table-driven sequence.
    for (int i = 0; i < 16; i++) begin
      bus.align_start = tbl[i].st;
      bus.frame_data  = tbl[i].d;
      for (int k = 0; k < tbl[i].n; k++) begin
        step();
        bus.align_start = 1'b0;
      end
      chk($sformatf("vec%0d", i), outs(), tbl[i].exp);
    end

    // Three slips with a rotating divider model.
    do_reset();
    off = 3;
    bus.frame_data = rot(PAT, off);
    bus.align_start = 1'b1;
    step();
    bus.align_start = 1'b0;
    pulses = 0; last = 0; cyc = 0;
    for (int i = 0; i < 300 && !bus.aligned; i++) begin
      step();
      cyc++;
      if (bus.bit_slip) begin
        if (pulses > 0) chk("slip_gap", cyc - last, 10);
        pulses++;
        last = cyc;
        off = (off + 7) % 8;
      end
      bus.frame_data = rot(PAT, off);
    end
    chk("three_pulses", pulses, 3);
    chk("three_aligned", bus.aligned, 1);
    chk("three_count", bus.slip_count, 3);

    // Match run broken after 15 matches.
    do_reset();
    bus.frame_data = PAT;
    bus.align_start = 1'b1;
    step();
    bus.align_start = 1'b0;
    repeat (15) step();
    chk("break_pre", bus.aligned, 0);
    bus.frame_data = 8'h00;
    step();
    chk("break_slip", outs(), ex(1, 0, 0, 0, 0));
    bus.frame_data = PAT;
    repeat (24) step();
    chk("break_not_yet", bus.aligned, 0);
    step();
    chk("break_lock", outs(), ex(0, 1, 0, 0, 1));

    // Asynchronous reset during SETTLE.
    do_reset();
    bus.frame_data = 8'h00;
    bus.align_start = 1'b1;
    step();
    bus.align_start = 1'b0;
    step();
    step();
    repeat (3) step();
    chk("pre_rst_count", bus.slip_count, 1);
    rst = 1'b1;
    #1;
    chk("rst_async", outs(), 8'h00);
    @(negedge clk);
    rst = 1'b0;
    bus.frame_data = PAT;
    repeat (20) step();
    chk("rst_idle", outs(), 8'h00);

    // Restart during SETTLE.
    bus.frame_data = 8'h00;
    bus.align_start = 1'b1;
    step();
    bus.align_start = 1'b0;
    step();
    step();
    repeat (3) step();
    bus.align_start = 1'b1;
    step();
    bus.align_start = 1'b0;
    chk("restart_clear", outs(), 8'h00);
    step();
    chk("restart_check", outs(), ex(1, 0, 0, 0, 0));

    // Random stimulus against the model.
    do_reset();
    model_reset();
    bad = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 599) == 0) begin
        rst = 1'b1;
        bus.align_start = 1'b0;
        model_reset();
        #1;
        chk("rand_rst", outs(), 8'h00);
        @(negedge clk);
        rst = 1'b0;
        continue;
      end
      if (i % 250 == 0) bad = ($urandom_range(0, 2) == 0);
      st = ($urandom_range(0, 149) == 0);
      if (bad)
        d = ($urandom_range(0, 7) == 0) ? PAT : 8'($urandom);
      else
        d = ($urandom_range(0, 39) == 0) ? 8'($urandom) : PAT;
      bus.align_start = st;
      bus.frame_data = d;
      model_step(st, d);
      step();
      chk($sformatf("rand%0d", i), outs(), model_out());
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/clkdiv_frame_align.md
# clkdiv_frame_align

Word-alignment controller for the ADC LVDS receive path. It runs in the divided (word) clock domain produced by the ICB_CLKDIV-based clock divider. It compares each deserialized frame-clock word against the expected pattern and issues single-cycle BIT_SLIP pulses to the divider until the word boundary is correct. It then reports lock and monitors the frame word continuously.

## Interface
Parameters:
- FRAME_PATTERN, 8'hF0, expected deserialized frame-clock word when aligned.
- MATCH_COUNT, 16, consecutive matching words required to declare lock (1..255).
- SETTLE_CYCLES, 8, wait cycles after each BIT_SLIP before comparing again (1..255).
- MAX_SLIPS, 8, slips attempted before declaring failure (1..15).

Ports:
- CLK  in  1  divided word clock (CLK_OUT of the clock divider).
- RST  in  1  asynchronous, active-high reset.
- ALIGN_START  in  1  one-cycle request to start or restart alignment.
- FRAME_DATA  in  8  deserialized frame-clock word, valid every CLK.
- BIT_SLIP  out  1  one-cycle slip pulse to the divider's BIT_SLIP input.
- ALIGNED  out  1  lock achieved and currently held.
- ALIGN_FAIL  out  1  MAX_SLIPS exhausted without lock; sticky until ALIGN_START or RST.
- LOCK_LOST  out  1  a mismatch was seen while locked; sticky until ALIGN_START or RST.
- SLIP_COUNT  out  4  slips issued in the current attempt.

## Operation
- Reset (async, RST=1): state IDLE; all outputs 0; match counter, settle counter and SLIP_COUNT are 0.
- FSM states:
  - IDLE: ALIGN_START goes to CHECK and clears SLIP_COUNT, ALIGN_FAIL, LOCK_LOST and the match counter.
  - CHECK: FRAME_DATA==FRAME_PATTERN increments the match counter; when it reaches MATCH_COUNT, go to LOCKED.
    - On a mismatch, clear the match counter.
    - On a mismatch with SLIP_COUNT==MAX_SLIPS, go to FAIL.
    - On any other mismatch, go to SLIP.
  - SLIP: assert BIT_SLIP for exactly one cycle, increment SLIP_COUNT, load the settle counter with SETTLE_CYCLES, go to SETTLE.
  - SETTLE: decrement the settle counter and ignore FRAME_DATA; at 0, go to CHECK.
  - LOCKED: ALIGNED=1; a mismatch sets LOCK_LOST, clears ALIGNED and goes to IDLE (default build).
  - FAIL: ALIGN_FAIL=1; stay in FAIL until ALIGN_START.
- ALIGN_START in any state restarts as if from IDLE, including an abort mid-SETTLE. A pending BIT_SLIP is never repeated.
- SLIP_COUNT saturates at 15. Because MAX_SLIPS ≤ 15, it never wraps.
- BIT_SLIP is never asserted on consecutive cycles; the minimum spacing is SETTLE_CYCLES+2.

## Timing
- All outputs are registered with no combinational input-to-output paths.
- BIT_SLIP rises in the cycle after the CHECK cycle that saw the mismatch.
- ALIGNED rises in the cycle after the MATCH_COUNT-th consecutive match.
- LOCK_LOST rises and ALIGNED falls in the cycle after the mismatching word.
- ALIGN_FAIL rises in the cycle after the mismatch that is seen with SLIP_COUNT==MAX_SLIPS.
- Worst-case lock time after ALIGN_START is MAX_SLIPS·(SETTLE_CYCLES+2) + MATCH_COUNT + 2 cycles.
- Mid-operation reset: all outputs are 0 immediately (asynchronous); the next attempt starts only on ALIGN_START.

## Configuration
- Macro: CLKDIV_FRAME_ALIGN_AUTO_REALIGN_EN.
- Defined: on a mismatch in LOCKED, LOCK_LOST is set and the FSM goes directly to SLIP with SLIP_COUNT cleared. No ALIGN_START is needed. LOCK_LOST stays sticky.
- Undefined: on a mismatch in LOCKED, the FSM goes to IDLE and waits for ALIGN_START.

## Test plan
- Already aligned: with defaults and FRAME_DATA=8'hF0 constant, pulse ALIGN_START → no BIT_SLIP, ALIGNED=1 16 cycles after entering CHECK, SLIP_COUNT=0.
- Three slips needed: a bench model rotates FRAME_DATA by one bit per BIT_SLIP, starting 3 rotations off → exactly 3 BIT_SLIP pulses, each 10 cycles apart, then ALIGNED=1, SLIP_COUNT=3.
- Never matches: FRAME_DATA=8'h00 → 8 BIT_SLIP pulses, then ALIGN_FAIL=1, ALIGNED=0, SLIP_COUNT=8, no further pulses; a subsequent ALIGN_START clears ALIGN_FAIL.
- Lock loss: after lock, inject one word of 8'hE1.
  - Default build: LOCK_LOST=1, ALIGNED=0, FSM in IDLE.
  - With the macro defined: the next cycle shows BIT_SLIP=1.
- Matching sequence break: 15 matches, 1 mismatch, then matches → BIT_SLIP issued and ALIGNED not asserted before a fresh run of 16 matches.
- Reset and restart mid-operation: assert RST during SETTLE → all outputs 0 asynchronously; ALIGN_START during SETTLE (no reset) → SLIP_COUNT=0 and the FSM in CHECK on the next cycle.
